// File: rtl/adxl345_i2c_sequencer.sv
// Drives the single-byte I2C engine for the ADXL345: runs the register-init table,
// then polls DATAX0..DATAZ1 at a fixed rate and publishes X/Y/Z samples.
module adxl345_i2c_sequencer #(
  parameter logic [6:0] DEV_ADDR    = 7'h1D,
  parameter int         POLL_DIV    = 500000,
  parameter int         TIMEOUT_CYC = 2000000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        enable,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic [6:0]  cmd_dev_addr,
  output logic [7:0]  cmd_reg_addr,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_rdata,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        fault
);

  localparam logic [31:0] DIV_LAST  = 32'(POLL_DIV - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
  localparam logic [7:0]  DATA_REG0 = 8'h32;

  typedef enum logic [2:0] {
    IDLE, INIT_ISSUE, INIT_WAIT, POLL_TIMER, RD_ISSUE, RD_WAIT, PUBLISH, FAULT
  } state_t;

  state_t      r_state;
  logic [2:0]  r_index;
  logic [7:0]  r_retry;
  logic [31:0] r_toCnt;
  logic [31:0] r_divCnt;
  logic [7:0]  r_shadow [0:4];
  logic        r_cmdValid;
  logic        r_cmdRw;
  logic [6:0]  r_cmdDevAddr;
  logic [7:0]  r_cmdRegAddr;
  logic [7:0]  r_cmdWdata;
  logic [15:0] r_accelX;
  logic [15:0] r_accelY;
  logic [15:0] r_accelZ;
  logic        r_sampleValid;
  logic        r_initDone;
  logic        r_fault;

  logic        w_accept;
  logic        w_rspOk;
  logic        w_rspFail;
  logic        w_inPoll;
  logic        w_divWrap;
  logic [2:0]  w_nextIndex;

  function automatic logic [7:0] initReg(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h2D;
      3'd1:    return 8'h31;
      3'd2:    return 8'h2C;
      default: return 8'h2D;
    endcase
  endfunction

  function automatic logic [7:0] initData(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h00;
      3'd1:    return 8'h04;
      3'd2:    return 8'h0F;
      default: return 8'h08;
    endcase
  endfunction

  assign w_accept    = r_cmdValid & cmd_ready;
  assign w_rspOk     = rsp_valid & ~rsp_nack;
  assign w_rspFail   = (rsp_valid & rsp_nack) | (~rsp_valid & (r_toCnt == TO_LAST));
  assign w_inPoll    = (r_state == POLL_TIMER) || (r_state == RD_ISSUE) ||
                       (r_state == RD_WAIT) || (r_state == PUBLISH);
  assign w_divWrap   = (r_divCnt == DIV_LAST);
  assign w_nextIndex = r_index + 3'd1;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_index       <= '0;
      r_retry       <= '0;
      r_toCnt       <= '0;
      r_divCnt      <= '0;
      for (int i = 0; i < 5; i++) r_shadow[i] <= '0;
      r_cmdValid    <= 1'b0;
      r_cmdRw       <= 1'b0;
      r_cmdDevAddr  <= '0;
      r_cmdRegAddr  <= '0;
      r_cmdWdata    <= '0;
      r_accelX      <= '0;
      r_accelY      <= '0;
      r_accelZ      <= '0;
      r_sampleValid <= 1'b0;
      r_initDone    <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_sampleValid <= 1'b0;
      // Divider free-runs from init_done so a slow burst never stretches the poll period.
      if (w_inPoll) r_divCnt <= w_divWrap ? '0 : r_divCnt + 32'd1;
      else          r_divCnt <= '0;

      case (r_state)
        IDLE: begin
          r_retry <= '0;
          if (enable) begin
            r_state      <= INIT_ISSUE;
            r_index      <= '0;
            r_initDone   <= 1'b0;
            r_cmdValid   <= 1'b1;
            r_cmdRw      <= 1'b0;
            r_cmdDevAddr <= DEV_ADDR;
            r_cmdRegAddr <= initReg(3'd0);
            r_cmdWdata   <= initData(3'd0);
          end
        end

        INIT_ISSUE, RD_ISSUE: begin
          if (w_accept) begin
            r_cmdValid <= 1'b0;
            r_toCnt    <= '0;
            r_state    <= (r_state == INIT_ISSUE) ? INIT_WAIT : RD_WAIT;
          end else if (!enable) begin
            r_cmdValid <= 1'b0;
            r_initDone <= 1'b0;
            r_state    <= IDLE;
          end
        end

        INIT_WAIT, RD_WAIT: begin
          r_toCnt <= r_toCnt + 32'd1;
          if (w_rspOk) begin
            r_retry <= '0;
            if (!enable) begin
              r_initDone <= 1'b0;
              r_state    <= IDLE;
            end else if (r_state == INIT_WAIT) begin
              if (r_index == 3'd3) begin
                r_initDone <= 1'b1;
                r_index    <= '0;
                r_state    <= POLL_TIMER;
              end else begin
                r_index      <= w_nextIndex;
                r_cmdValid   <= 1'b1;
                r_cmdRegAddr <= initReg(w_nextIndex);
                r_cmdWdata   <= initData(w_nextIndex);
                r_state      <= INIT_ISSUE;
              end
            end else if (r_index == 3'd5) begin
              // Last byte goes straight from the response so all three axes change together.
              r_accelX      <= {r_shadow[1], r_shadow[0]};
              r_accelY      <= {r_shadow[3], r_shadow[2]};
              r_accelZ      <= {rsp_rdata, r_shadow[4]};
              r_sampleValid <= 1'b1;
              r_state       <= PUBLISH;
            end else begin
              r_shadow[r_index] <= rsp_rdata;
              r_index           <= w_nextIndex;
              r_cmdValid        <= 1'b1;
              r_cmdRegAddr      <= DATA_REG0 + {5'd0, w_nextIndex};
              r_state           <= RD_ISSUE;
            end
          end else if (w_rspFail) begin
            if (!enable) begin
              r_initDone <= 1'b0;
              r_state    <= IDLE;
            end else if (r_retry == RETRY_MAX) begin
              r_fault    <= 1'b1;
              r_initDone <= 1'b0;
              r_state    <= FAULT;
            end else begin
              r_retry    <= r_retry + 8'd1;
              r_cmdValid <= 1'b1;
              r_state    <= (r_state == INIT_WAIT) ? INIT_ISSUE : RD_ISSUE;
            end
          end
        end

        POLL_TIMER: begin
          if (!enable) begin
            r_initDone <= 1'b0;
            r_state    <= IDLE;
          end else if (w_divWrap) begin
            r_index      <= '0;
            r_cmdValid   <= 1'b1;
            r_cmdRw      <= 1'b1;
            r_cmdRegAddr <= DATA_REG0;
            r_cmdWdata   <= 8'h00;
            r_state      <= RD_ISSUE;
          end
        end

        PUBLISH: begin
          if (!enable) begin
            r_initDone <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_state <= POLL_TIMER;
          end
        end

        FAULT: begin
          r_cmdValid <= 1'b0;
          r_initDone <= 1'b0;
          if (!enable) begin
            r_fault <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_valid    = r_cmdValid;
  assign cmd_rw       = r_cmdRw;
  assign cmd_dev_addr = r_cmdDevAddr;
  assign cmd_reg_addr = r_cmdRegAddr;
  assign cmd_wdata    = r_cmdWdata;
  assign accel_x      = r_accelX;
  assign accel_y      = r_accelY;
  assign accel_z      = r_accelZ;
  assign sample_valid = r_sampleValid;
  assign init_done    = r_initDone;
  assign fault        = r_fault;

endmodule

// File: tb/tb_adxl345_i2c_sequencer.sv
// Bench for adxl345_i2c_sequencer: a behavioural I2C engine plus a sample model
// drive init, poll bursts, retry, fault and disable scenarios.
module tb_adxl345_i2c_sequencer;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [6:0]  cmd_dev_addr;
  logic [7:0]  cmd_reg_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_nack;
  logic [7:0]  rsp_rdata;
  logic [15:0] accel_x;
  logic [15:0] accel_y;
  logic [15:0] accel_z;
  logic        sample_valid;
  logic        init_done;
  logic        fault;

  adxl345_i2c_sequencer #(
    .DEV_ADDR(7'h1D), .POLL_DIV(200), .TIMEOUT_CYC(100), .MAX_RETRY(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .init_done(init_done), .fault(fault)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cycle = 0;
  always @(posedge CLOCK_50) cycle++;

  typedef struct {
    logic [5:0][7:0] b;
    logic [15:0]     ex;
    logic [15:0]     ey;
    logic [15:0]     ez;
    int              delay;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] initTbl [4] = '{16'h2D00, 16'h3104, 16'h2C0F, 16'h2D08};
  int          retrySeq [6] = '{0, 1, 1, 1, 2, 3};

  int testsRun = 0;
  int testsFailed = 0;

  logic [5:0][7:0] rdBytes = '0;
  int              respDelay = 0;
  bit              silent = 1'b0;
  logic [7:0]      nackReg = 8'h00;
  int              nackLeft = 0;
  int              rspCount = 0;
  int              protoErr = 0;
  logic [23:0]     cmdLog [$];
  int              burstStarts [$];

  bit         engPending = 1'b0;
  int         engCnt = 0;
  logic [7:0] engReg = 8'h00;
  logic       engRw = 1'b0;
  logic       engPrevValid = 1'b0;

  function automatic logic [23:0] mkCmd(input logic rw, input logic [7:0] regA, input logic [7:0] wd);
    return {rw, 7'h1D, regA, wd};
  endfunction

  function automatic logic [15:0] combine(input logic [7:0] hi, input logic [7:0] lo);
    return 16'(int'(hi) * 256 + int'(lo));
  endfunction

  function automatic bit sigSel(input int sel);
    case (sel)
      0:       return cmd_valid;
      1:       return init_done;
      2:       return sample_valid;
      default: return fault;
    endcase
  endfunction

  // Behavioural I2C engine: sees accepts at the negedge before the accepting posedge.
  initial begin
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    rsp_rdata = 8'h00;
    forever begin
      @(negedge CLOCK_50);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      rsp_rdata = 8'h00;
      if (!reset_n) begin
        engPending   = 1'b0;
        engPrevValid = 1'b0;
      end else begin
        if (cmd_valid && !engPrevValid && cmd_rw && cmd_reg_addr == 8'h32)
          burstStarts.push_back(cycle);
        engPrevValid = cmd_valid;
        if (engPending) begin
          if (cmd_valid) protoErr++;
          if (engCnt == 0) begin
            engPending = 1'b0;
            rsp_valid  = 1'b1;
            rspCount++;
            if (!engRw && engReg == nackReg && nackLeft > 0) begin
              rsp_nack = 1'b1;
              nackLeft--;
            end else if (engRw) begin
              rsp_rdata = rdBytes[3'(engReg - 8'h32)];
            end
          end else begin
            engCnt--;
          end
        end else if (cmd_valid && cmd_ready) begin
          cmdLog.push_back({cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_wdata});
          if (!silent) begin
            engPending = 1'b1;
            engCnt     = respDelay;
            engReg     = cmd_reg_addr;
            engRw      = cmd_rw;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable    = en;
    cmd_ready = rdy;
  endtask

  task automatic waitFor(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLOCK_50);
      if (sigSel(sel)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1);
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int base, rbase, holdViol, stableViol, pulses, bad;
    logic [23:0] cap;
    logic [15:0] heldX, heldY, heldZ;

    vecs[0].b = 48'h7F80_0002_FF10;
    vecs[0].ex = 16'hFF10; vecs[0].ey = 16'h0002; vecs[0].ez = 16'h7F80;
    vecs[0].delay = 5;
    for (int k = 1; k < 8; k++) begin
      for (int j = 0; j < 6; j++) vecs[k].b[j] = 8'($urandom_range(255, 0));
      vecs[k].ex    = combine(vecs[k].b[1], vecs[k].b[0]);
      vecs[k].ey    = combine(vecs[k].b[3], vecs[k].b[2]);
      vecs[k].ez    = combine(vecs[k].b[5], vecs[k].b[4]);
      vecs[k].delay = $urandom_range(10, 0);
    end

    // Reset values
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    checkOutput("rst_cmd_valid", cmd_valid, 0);
    checkOutput("rst_cmd_rw", cmd_rw, 0);
    checkOutput("rst_dev_addr", cmd_dev_addr, 0);
    checkOutput("rst_reg_addr", cmd_reg_addr, 0);
    checkOutput("rst_wdata", cmd_wdata, 0);
    checkOutput("rst_accel", {accel_x, accel_y, accel_z} == 48'h0, 1);
    checkOutput("rst_flags", {sample_valid, init_done, fault}, 0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);

    // Init table with the engine stalling ready for 50 cycles on the first command
    respDelay = 20;
    base  = cmdLog.size();
    rbase = rspCount;
    applyStimulus(1'b1, 1'b0);
    waitFor(0, 20, ok);
    checkOutput("init_first_valid", ok, 1);
    cap = {cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_wdata};
    checkOutput("init_first_cmd", cap, mkCmd(1'b0, 8'h2D, 8'h00));
    holdViol = 0;
    repeat (50) begin
      @(negedge CLOCK_50);
      if (!cmd_valid || {cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_wdata} != cap) holdViol++;
    end
    checkOutput("hold_stable", holdViol, 0);
    checkOutput("hold_no_accept", cmdLog.size() - base, 0);
    cmd_ready = 1'b1;
    waitFor(1, 2000, ok);
    checkOutput("init_done_seen", ok, 1);
    checkOutput("init_done_after_rsp4", rspCount - rbase, 4);
    checkOutput("init_cmd_count", cmdLog.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < cmdLog.size())
        checkOutput("init_cmd", cmdLog[base + i], mkCmd(1'b0, initTbl[i][15:8], initTbl[i][7:0]));

    // Poll bursts: table of byte patterns against the sample model
    burstStarts.delete();
    heldX = 16'h0; heldY = 16'h0; heldZ = 16'h0;
    for (int k = 0; k < 8; k++) begin
      rdBytes    = vecs[k].b;
      respDelay  = vecs[k].delay;
      base       = cmdLog.size();
      stableViol = 0;
      ok         = 1'b0;
      for (int c = 0; c < 600 && !ok; c++) begin
        @(negedge CLOCK_50);
        if (sample_valid) ok = 1'b1;
        else if ({accel_x, accel_y, accel_z} !== {heldX, heldY, heldZ}) stableViol++;
      end
      checkOutput("poll_sample_seen", ok, 1);
      checkOutput("accel_x", accel_x, vecs[k].ex);
      checkOutput("accel_y", accel_y, vecs[k].ey);
      checkOutput("accel_z", accel_z, vecs[k].ez);
      checkOutput("accel_hold_in_burst", stableViol, 0);
      checkOutput("rd_cmd_count", cmdLog.size() - base, 6);
      bad = 0;
      for (int i = 0; i < 6; i++)
        if (base + i >= cmdLog.size() || cmdLog[base + i] != mkCmd(1'b1, 8'(8'h32 + i), 8'h00)) bad++;
      checkOutput("rd_cmd_fields", bad, 0);
      @(negedge CLOCK_50);
      checkOutput("sample_valid_width", sample_valid, 0);
      checkOutput("burst_count", burstStarts.size(), k + 1);
      if (k > 0 && burstStarts.size() >= 2)
        checkOutput("burst_period", burstStarts[$] - burstStarts[$-1], 200);
      heldX = vecs[k].ex; heldY = vecs[k].ey; heldZ = vecs[k].ez;
    end

    // NACK on the first two attempts of reg 0x31, then recovery
    doReset();
    nackReg   = 8'h31;
    nackLeft  = 2;
    respDelay = 5;
    base      = cmdLog.size();
    applyStimulus(1'b1, 1'b1);
    waitFor(1, 500, ok);
    checkOutput("retry_init_done", ok, 1);
    checkOutput("retry_fault", fault, 0);
    checkOutput("retry_cmd_count", cmdLog.size() - base, 6);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (base + i >= cmdLog.size() ||
          cmdLog[base + i] != mkCmd(1'b0, initTbl[retrySeq[i]][15:8], initTbl[retrySeq[i]][7:0])) bad++;
    checkOutput("retry_cmd_seq", bad, 0);
    nackLeft = 0;

    // Silent engine: every attempt times out, four attempts then fault
    doReset();
    silent = 1'b1;
    base   = cmdLog.size();
    applyStimulus(1'b1, 1'b1);
    waitFor(3, 1000, ok);
    checkOutput("fault_seen", ok, 1);
    checkOutput("fault_attempts", cmdLog.size() - base, 4);
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (base + i >= cmdLog.size() || cmdLog[base + i] != mkCmd(1'b0, 8'h2D, 8'h00)) bad++;
    checkOutput("fault_attempt_fields", bad, 0);
    checkOutput("fault_init_done", init_done, 0);
    holdViol = 0;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (cmd_valid || !fault) holdViol++;
    end
    checkOutput("fault_quiet", holdViol, 0);
    checkOutput("fault_no_more_cmds", cmdLog.size() - base, 4);
    enable = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("fault_cleared", fault, 0);
    silent    = 1'b0;
    respDelay = 3;
    enable    = 1'b1;
    waitFor(0, 10, ok);
    checkOutput("reinit_valid", ok, 1);
    checkOutput("reinit_cmd", {cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_wdata}, mkCmd(1'b0, 8'h2D, 8'h00));

    // Disable after byte 2 of a burst is accepted
    waitFor(1, 500, ok);
    checkOutput("dis_init_done", ok, 1);
    rdBytes = vecs[1].b;
    waitFor(2, 600, ok);
    checkOutput("dis_first_sample", ok, 1);
    checkOutput("dis_first_x", accel_x, vecs[1].ex);
    rdBytes   = vecs[2].b;
    respDelay = 10;
    @(negedge CLOCK_50);
    base  = cmdLog.size();
    rbase = rspCount;
    ok    = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge CLOCK_50);
      if (cmdLog.size() >= base + 3) ok = 1'b1;
    end
    checkOutput("dis_byte2_accepted", ok, 1);
    enable = 1'b0;
    pulses = 0;
    repeat (300) begin
      @(negedge CLOCK_50);
      if (sample_valid) pulses++;
    end
    checkOutput("dis_no_publish", pulses, 0);
    checkOutput("dis_cmd_count", cmdLog.size() - base, 3);
    if (cmdLog.size() >= base + 3)
      checkOutput("dis_byte2_cmd", cmdLog[base + 2], mkCmd(1'b1, 8'h34, 8'h00));
    checkOutput("dis_rsp_done", rspCount - rbase, 3);
    checkOutput("dis_accel_hold", {accel_x, accel_y, accel_z} == {vecs[1].ex, vecs[1].ey, vecs[1].ez}, 1);
    checkOutput("dis_init_done_low", init_done, 0);
    checkOutput("dis_cmd_valid_low", cmd_valid, 0);
    enable = 1'b1;
    waitFor(0, 10, ok);
    checkOutput("dis_reenable_valid", ok, 1);
    checkOutput("dis_reenable_cmd", {cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_wdata}, mkCmd(1'b0, 8'h2D, 8'h00));

    // Reset mid-transaction returns everything to zero
    repeat (5) @(negedge CLOCK_50);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("midrst_accel", {accel_x, accel_y, accel_z} == 48'h0, 1);
    checkOutput("midrst_flags", {cmd_valid, init_done, fault, sample_valid}, 0);
    reset_n = 1'b1;
    enable  = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    checkOutput("engine_protocol", protoErr, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/adxl345_i2c_sequencer.md
Name: adxl345_i2c_sequencer

Overview:
- Sequences the single-byte I2C transaction engine that talks to the on-board ADXL345.
- Runs a fixed register-init table, then polls the six data registers (0x32..0x37) at a programmable rate.
- Publishes signed 16-bit X/Y/Z samples to downstream logic.
- Handles NACK/timeout retry. The I2C engine never needs to know which device register means what.

Parameters:
- DEV_ADDR, 7'h1D, 7-bit I2C slave address placed on every command.
- POLL_DIV, 500000, CLOCK_50 cycles between poll-burst starts (100 Hz); minimum 64.
- TIMEOUT_CYC, 2000000, cycles from command accept to rsp_valid before the attempt counts as failed.
- MAX_RETRY, 3, retries per transaction after the first failed attempt.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request. Level-sensitive.
- cmd_valid  out  1  command to engine valid.
- cmd_ready  in  1  engine accepts command.
- cmd_rw  out  1  0 = write, 1 = read.
- cmd_dev_addr  out  7  always DEV_ADDR.
- cmd_reg_addr  out  8  register address.
- cmd_wdata  out  8  write data; 0 for reads.
- rsp_valid  in  1  one-cycle pulse, transaction finished.
- rsp_nack  in  1  qualified by rsp_valid; 1 = slave NACK.
- rsp_rdata  in  8  qualified by rsp_valid; read byte.
- accel_x, accel_y, accel_z  out  16 each  latest sample, {high byte, low byte}.
- sample_valid  out  1  one-cycle pulse when X/Y/Z update.
- init_done  out  1  init table completed.
- fault  out  1  sticky; retries exhausted.

Behaviour:
- Reset (reset_n low, async):
  - All outputs 0: cmd_valid, cmd_*, accel_*, sample_valid, init_done, fault.
  - FSM state = IDLE; all counters 0.
- Init table, entries 0..3 as (reg, data):
  - 0: (0x2D, 0x00) standby
  - 1: (0x31, 0x04)
  - 2: (0x2C, 0x0F)
  - 3: (0x2D, 0x08) measure
- FSM states: IDLE, INIT_ISSUE, INIT_WAIT, POLL_TIMER, RD_ISSUE, RD_WAIT, PUBLISH, FAULT.
- IDLE:
  - enable=1 -> INIT_ISSUE with index=0, init_done=0.
- *_ISSUE states:
  - cmd_valid=1. Fields stay stable until the cycle where cmd_valid & cmd_ready are both high (accept).
  - On accept -> matching *_WAIT. cmd_valid drops the cycle after accept.
  - The timeout counter clears on accept.
- *_WAIT states:
  - cmd_valid=0.
  - A failure is rsp_valid & rsp_nack, or timeout counter reaching TIMEOUT_CYC-1.
  - On failure with retry < MAX_RETRY: retry+1, return to the same ISSUE with identical fields.
  - On failure with retry = MAX_RETRY: -> FAULT.
  - On success: retry cleared.
  - rsp_valid arriving in any state other than a WAIT state is ignored.
- INIT success:
  - Index 0..2: index+1 -> INIT_ISSUE.
  - Index 3: init_done=1 -> POLL_TIMER.
- POLL_TIMER:
  - The divider counts 0..POLL_DIV-1 continuously from init_done. Overruns do not stretch the period.
  - When the count wraps to 0 -> RD_ISSUE with byte index=0.
- RD_ISSUE / RD_WAIT:
  - cmd_rw=1, cmd_reg_addr = 0x32 + byte index.
  - On success, rsp_rdata goes into shadow byte[index].
  - Index 0..4: index+1 -> RD_ISSUE. Index 5 -> PUBLISH.
  - If a divider wrap occurs while a burst is in progress, that wrap is dropped (no queuing).
- PUBLISH, one cycle:
  - accel_x={b1,b0}, accel_y={b3,b2}, accel_z={b5,b4}; sample_valid=1 for exactly this cycle.
  - -> POLL_TIMER.
  - Outputs update atomically; a partial burst never alters accel_*.
- FAULT:
  - fault=1, init_done=0, cmd_valid=0, accel_* hold.
  - Leave only via enable=0 -> IDLE, which clears fault.
- enable deasserted in any non-FAULT state:
  - An outstanding accepted command runs to rsp_valid or timeout.
  - An unaccepted cmd_valid may be withdrawn immediately.
  - Then -> IDLE with init_done=0. accel_* hold.
  - Re-enable reruns the full init table.
- Reset mid-transaction: immediate return to reset values. A late rsp_valid from the engine is ignored in IDLE.

Test Plan:
- Init sequence: reset, enable=1, engine ready=1 and ACKs each command after 20 cycles -> four writes (2D/00, 31/04, 2C/0F, 2D/08) in order; init_done=1 after the 4th rsp; cmd_dev_addr=0x1D throughout.
- Poll burst: POLL_DIV=200, engine returns bytes 0x10,0xFF,0x02,0x00,0x80,0x7F for regs 0x32..0x37 -> one sample_valid pulse; accel_x=0xFF10, accel_y=0x0002, accel_z=0x7F80; next burst starts 200 cycles after the previous one.
- Handshake hold: cmd_ready held low 50 cycles -> cmd_valid and fields stable all 50 cycles; exactly one accept; no duplicate command.
- Retry then recover: NACK on the first two attempts of reg 0x31 -> three identical commands, init proceeds, fault=0.
- Fault: timeout on every attempt with TIMEOUT_CYC=100, MAX_RETRY=3 -> four attempts, then fault=1, cmd_valid stays 0; enable low for 1 cycle -> fault=0, IDLE; enable high -> init restarts at 0x2D/0x00.
- Disable mid-burst: enable=0 after byte 2 accepted -> that response completes, no PUBLISH, accel_* unchanged, init_done=0.
